// File: rtl/arb8_hold_ctrl_pkg.sv
// Shared types and constants for the 8-way hold arbiter.
// FSM encodings, requester count, index width, rotate helper.
package arb8_hold_ctrl_pkg;

  localparam int NREQ = 8;
  localparam int IDW  = 3;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_PARK = 2'd2
  } state_t;

  function automatic logic [NREQ-1:0] onehot8(
    input logic [IDW-1:0] i
  );
    logic [NREQ-1:0] one;
    one = {{(NREQ-1){1'b0}}, 1'b1};
    return one << i;
  endfunction

  // rotate right: result[j] = v[(j+s) mod 8]
  function automatic logic [NREQ-1:0] rotr8(
    input logic [NREQ-1:0] v,
    input logic [IDW-1:0]  s
  );
    logic [2*NREQ-1:0] d;
    d = {v, v} >> s;
    return d[NREQ-1:0];
  endfunction

endpackage

// File: rtl/arb8_hold_ctrl_pick8.sv
// Highest-set-bit picker for an 8-bit candidate vector.
// Ports: cand in; idx = highest set index, any = cand non-zero.
module arb_pick8
  import arb8_hold_ctrl_pkg::*;
(
  input  logic [7:0] cand,
  output logic [2:0] idx,
  output logic       any
);

  always_comb begin
    idx = 3'd0;
    any = |cand;
    priority case (1'b1)
      cand[7]: idx = 3'd7;
      cand[6]: idx = 3'd6;
      cand[5]: idx = 3'd5;
      cand[4]: idx = 3'd4;
      cand[3]: idx = 3'd3;
      cand[2]: idx = 3'd2;
      cand[1]: idx = 3'd1;
      cand[0]: idx = 3'd0;
      default: idx = 3'd0;
    endcase
  end

endmodule

// File: rtl/arb8_hold_ctrl.sv
// 8-requester arbiter: owner keeps grant until release or MAX_HOLD timeout.
// Ports: clk, rst_n, en, req[7:0] in; gnt, gnt_id, gnt_vld, timeout out.
// Option: ARB8_ROUND_ROBIN_EN rotates priority after each grant.
module arb8_hold_ctrl
  import arb8_hold_ctrl_pkg::*;
#(
  parameter int MAX_HOLD = 16,
  parameter int CW       = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       en,
  input  logic [7:0] req,
  output logic [7:0] gnt,
  output logic [2:0] gnt_id,
  output logic       gnt_vld,
  output logic       timeout
);

  localparam logic [CW-1:0] HOLD_MAX = CW'(MAX_HOLD);

  state_t          state_q, state_d;
  logic [NREQ-1:0] gnt_q, gnt_d;
  logic [IDW-1:0]  id_q, id_d;
  logic            vld_q, vld_d;
  logic            to_q, to_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [NREQ-1:0] mask_q, mask_d;

  logic [NREQ-1:0] cand;
  logic [NREQ-1:0] pick_in;
  logic [IDW-1:0]  pick_idx;
  logic            pick_any;
  logic [IDW-1:0]  win;

`ifdef ARB8_ROUND_ROBIN_EN
  logic [IDW-1:0]  ptr_q, ptr_d;
`endif

  assign cand = req & mask_q;

`ifdef ARB8_ROUND_ROBIN_EN
  // rotated bit 7 is cand[ptr-1], so the last winner's
  // lower neighbour gets first pick; 3-bit add unrotates
  assign pick_in = rotr8(cand, ptr_q);
  assign win     = pick_idx + ptr_q;
`else
  assign pick_in = cand;
  assign win     = pick_idx;
`endif

  arb_pick8 u_pick (
    .cand (pick_in),
    .idx  (pick_idx),
    .any  (pick_any)
  );

  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    id_d    = id_q;
    vld_d   = vld_q;
    to_d    = 1'b0;
    cnt_d   = cnt_q;
    mask_d  = mask_q;
`ifdef ARB8_ROUND_ROBIN_EN
    ptr_d   = ptr_q;
`endif
    unique case (state_q)
      ST_IDLE: begin
        gnt_d = '0;
        vld_d = 1'b0;
        cnt_d = '0;
        if (en && pick_any) begin
          state_d = ST_BUSY;
          gnt_d   = onehot8(win);
          id_d    = win;
          vld_d   = 1'b1;
          cnt_d   = CW'(1);
          mask_d  = '1;
`ifdef ARB8_ROUND_ROBIN_EN
          ptr_d   = win;
`endif
        end else if (!pick_any && (|req)) begin
          // only masked requesters left: unmask so
          // they can win on the next cycle
          mask_d = '1;
        end
      end
      ST_BUSY: begin
        if (!req[id_q]) begin
          state_d = ST_PARK;
          gnt_d   = '0;
          vld_d   = 1'b0;
        end else if (cnt_q >= HOLD_MAX) begin
          state_d = ST_PARK;
          gnt_d   = '0;
          vld_d   = 1'b0;
          to_d    = 1'b1;
          mask_d  = ~gnt_q;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      ST_PARK: begin
        state_d = ST_IDLE;
        gnt_d   = '0;
        vld_d   = 1'b0;
      end
      default: begin
        state_d = ST_IDLE;
        gnt_d   = '0;
        vld_d   = 1'b0;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      gnt_q   <= '0;
      id_q    <= '0;
      vld_q   <= 1'b0;
      to_q    <= 1'b0;
      cnt_q   <= '0;
      mask_q  <= '1;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      id_q    <= id_d;
      vld_q   <= vld_d;
      to_q    <= to_d;
      cnt_q   <= cnt_d;
      mask_q  <= mask_d;
    end
  end

`ifdef ARB8_ROUND_ROBIN_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q <= '0;
    end else begin
      ptr_q <= ptr_d;
    end
  end
`endif

  assign gnt     = gnt_q;
  assign gnt_id  = id_q;
  assign gnt_vld = vld_q;
  assign timeout = to_q;

endmodule
